// File: rtl/iir_sample_feeder_pkg.sv
// Shared constants, FSM encoding and the saturating pre-scale helper
// for the IIR biquad input feeder.
package iir_sample_feeder_pkg;

   localparam int DW        = 18;
   localparam int FRAME_LEN = 7;
   localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

   // Limits expressed in the widest pre-scale width (DW + max shift of 4).
   localparam logic signed [DW+3:0] VMAX = {5'b00000, {(DW-1){1'b1}}};
   localparam logic signed [DW+3:0] VMIN = {5'b11111, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   function automatic logic [DW-1:0] sat_shift(input logic [DW-1:0] x, input int unsigned sh);
      logic signed [DW+3:0] v;
      v = $signed({{4{x[DW-1]}}, x}) <<< sh;
      if (v > VMAX)      return MAXV;
      else if (v < VMIN) return MINV;
      else               return v[DW-1:0];
   endfunction

endpackage

// File: rtl/iir_sample_feeder_if.sv
// Sample stream in, held sample / start pulse out, frame-complete pulse back.
interface iir_sample_feeder_if;
   import iir_sample_feeder_pkg::*;

   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          dout_valid;

   modport slave  (input s_data, s_valid, dout_valid, output s_ready, din, din_valid);
   modport master (output s_data, s_valid, dout_valid, input s_ready, din, din_valid);
endinterface

// File: rtl/iir_sample_feeder_fifo.sv
// Synchronous FIFO with occupancy count; the popped word lands in a
// read-data register that holds until the next pop.
module iir_sample_feeder_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic [AW:0]  level,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            rdata  <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/iir_sample_feeder.sv
// Buffers upstream samples and hands them to the biquad one frame at a time,
// holding din until the filter reports frame completion or the wait times out.
module iir_sample_feeder
   import iir_sample_feeder_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int SHIFT   = 0,
   parameter int TIMEOUT = 2 * FRAME_LEN + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   iir_sample_feeder_if.slave    bus,
   output logic [AW:0]           level,
   output logic                  busy,
   output logic                  err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic          push, pop, full, empty, timeout_hit;
   logic [DW-1:0] rdata;

   assign bus.s_ready = rst & ~full;
   assign push        = bus.s_valid & bus.s_ready;

   iir_sample_feeder_fifo #(.W(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (bus.s_data),
      .pop   (pop),
      .rdata (rdata),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // Scaling sits after the read register, so din only moves on a pop.
   assign bus.din       = sat_shift(rdata, SHIFT);
   assign bus.din_valid = (state == S_ISSUE);
   assign busy          = (state != S_IDLE);

   always_comb begin
      nxt         = state;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: if (!empty) begin
            pop = 1'b1;
            nxt = S_ISSUE;
         end
         S_ISSUE: nxt = S_WAIT;
         S_WAIT: begin
            if (bus.dout_valid) begin
               pop = ~empty;
               nxt = empty ? S_IDLE : S_ISSUE;
            end else if (cnt == CW'(TIMEOUT)) begin
               timeout_hit = 1'b1;
               nxt         = S_IDLE;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_ISSUE)     cnt <= '0;
         else if (state == S_WAIT) cnt <= cnt + CW'(1);
         if (timeout_hit) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_iir_sample_feeder.sv
// Scoreboarded bench: inputs captured at acceptance feed an expected queue,
// a monitor checks every din_valid issue plus level/ready/hold rules.
module tb_iir_sample_feeder;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0, errors = 0;

   iir_sample_feeder_if ifa ();
   iir_sample_feeder_if ifb ();
   logic [3:0] level_a, level_b;
   logic       busy_a, busy_b, err_a, err_b;

   iir_sample_feeder #(.SHIFT(0)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .level(level_a), .busy(busy_a), .err(err_a));
   iir_sample_feeder #(.SHIFT(2)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .level(level_b), .busy(busy_b), .err(err_b));

   always #5 clk = ~clk;
   initial forever @(posedge clk) cyc++;

   logic [17:0] sb_a[$], sb_b[$];
   bit  withhold = 0, rate_chk = 0, saw_full = 0;
   int  dv_a = 0, dv_b = 0, last_dv = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: arithmetic left shift then clamp to the signed DW range.
   function automatic logic [17:0] ref_scale(input logic [17:0] x, input int sh);
      longint v;
      logic [63:0] u;
      v = longint'($signed(x));
      for (int i = 0; i < sh; i++) v = v * 2;
      if (v > 131071)  return 18'h1FFFF;
      if (v < -131072) return 18'h20000;
      u = 64'(v);
      return u[17:0];
   endfunction

   // Filter models: dout_valid 6 cycles after the start pulse.
   initial begin
      int fc = 0;
      ifa.dout_valid = 0;
      forever begin
         @(posedge clk); #1;
         ifa.dout_valid = 0;
         if (!rst) fc = 0;
         else begin
            if (fc > 0) begin
               fc--;
               if (fc == 0 && !withhold) ifa.dout_valid = 1;
            end
            if (ifa.din_valid) fc = 6;
         end
      end
   end

   initial begin
      int fc = 0;
      ifb.dout_valid = 0;
      forever begin
         @(posedge clk); #1;
         ifb.dout_valid = 0;
         if (!rst) fc = 0;
         else begin
            if (fc > 0) begin
               fc--;
               if (fc == 0) ifb.dout_valid = 1;
            end
            if (ifb.din_valid) fc = 6;
         end
      end
   end

   // Monitor A
   initial begin
      int prev_level = 0;
      bit prev_push = 0, have_prev = 0;
      logic [17:0] held = '0, e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            have_prev = 0;
            held = '0;
         end else begin
            if (have_prev)
               chk("level_rule", 32'(level_a), 32'(prev_level + int'(prev_push) - int'(ifa.din_valid)));
            chk("s_ready_vs_full", 32'(ifa.s_ready), 32'(level_a != 4'd8));
            if (!ifa.s_ready) saw_full = 1;
            if (ifa.din_valid) begin
               dv_a++;
               if (sb_a.size() == 0) chk("issue_expected", 0, 1);
               else begin
                  e = sb_a.pop_front();
                  chk("din_a", 32'(ifa.din), 32'(e));
               end
               held = ifa.din;
               if (rate_chk && last_dv >= 0) chk("issue_spacing", 32'(cyc - last_dv), 7);
               last_dv = cyc;
            end else if (busy_a) chk("din_hold", 32'(ifa.din), 32'(held));
            prev_level = int'(level_a);
            prev_push  = ifa.s_valid & ifa.s_ready;
            have_prev  = 1;
            if (prev_push) sb_a.push_back(ref_scale(ifa.s_data, 0));
         end
      end
   end

   // Monitor B
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (ifb.din_valid) begin
               dv_b++;
               if (sb_b.size() == 0) chk("issue_expected_b", 0, 1);
               else begin
                  e = sb_b.pop_front();
                  chk("din_b", 32'(ifb.din), 32'(e));
               end
            end
            if (ifb.s_valid & ifb.s_ready) sb_b.push_back(ref_scale(ifb.s_data, 2));
         end
      end
   end

   // Stimulus tasks: called and return at posedge + #2.
   task automatic push_a(input logic [17:0] d);
      int n = 0;
      ifa.s_data  = d;
      ifa.s_valid = 1;
      while (!ifa.s_ready && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 200) chk("push_a_timeout", 1, 0);
      @(posedge clk); #2;
      ifa.s_valid = 0;
   endtask

   task automatic push_b(input logic [17:0] d);
      int n = 0;
      ifb.s_data  = d;
      ifb.s_valid = 1;
      while (!ifb.s_ready && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 200) chk("push_b_timeout", 1, 0);
      @(posedge clk); #2;
      ifb.s_valid = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_idle_a();
      int n = 0;
      while ((busy_a || level_a != 0) && n < 2000) begin cycles(1); n++; end
      chk("drain_a", 32'(n < 2000), 1);
      cycles(2);
   endtask

   task automatic wait_dv_a(output int at);
      int n = 0;
      at = -1;
      while (n < 50) begin
         @(negedge clk);
         if (ifa.din_valid) begin at = cyc; break; end
         n++;
      end
      chk("din_valid_seen", 32'(at >= 0), 1);
      @(posedge clk); #2;
   endtask

   initial begin
      int t0, t1, te, n, c;
      bit done;
      rst = 0;
      ifa.s_valid = 0; ifa.s_data = '0;
      ifb.s_valid = 0; ifb.s_data = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_level", 32'(level_a), 0);
      chk("rst_din", 32'(ifa.din), 0);
      chk("rst_din_valid", 32'(ifa.din_valid), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_err", 32'(err_a), 0);
      chk("rst_s_ready", 32'(ifa.s_ready), 0);
      rst = 1;
      cycles(2);

      // 1: single sample latency and value
      t0 = cyc;
      push_a(18'h00123);
      wait_dv_a(t1);
      chk("first_issue_latency", 32'(t1 - t0), 2);
      wait_idle_a();

      // 2: burst of 10 with s_valid held; fills FIFO, 7-cycle pacing
      saw_full = 0; rate_chk = 1; last_dv = -1; c = dv_a;
      for (int i = 0; i < 10; i++) push_a(18'($urandom));
      wait_idle_a();
      rate_chk = 0;
      chk("burst_saw_full", 32'(saw_full), 1);
      chk("burst_issue_count", 32'(dv_a - c), 10);

      // 3: saturating pre-scale on the SHIFT=2 instance
      push_b(18'h0FFFF);
      push_b(18'h30000);
      push_b(18'h00100);
      for (int i = 0; i < 20; i++) begin
         push_b(18'($urandom));
         cycles($urandom_range(0, 8));
      end
      n = 0;
      while ((busy_b || level_b != 0) && n < 2000) begin cycles(1); n++; end
      cycles(2);
      chk("b_issue_count", 32'(dv_b), 23);
      chk("b_sb_empty", 32'(sb_b.size()), 0);
      chk("b_err_clear", 32'(err_b), 0);

      // 4: withheld dout_valid -> timeout, sticky err, feeder recovers
      withhold = 1;
      push_a(18'($urandom));
      wait_dv_a(t1);
      te = -1; n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (err_a) begin te = cyc; break; end
         n++;
      end
      chk("timeout_cycle", 32'(te - t1), 17);
      chk("timeout_idle", 32'(busy_a), 0);
      @(posedge clk); #2;
      withhold = 0;
      push_a(18'($urandom));
      wait_idle_a();
      chk("err_sticky", 32'(err_a), 1);
      chk("sb_a_empty_t4", 32'(sb_a.size()), 0);

      // 5: reset mid-WAIT with 5 samples queued
      for (int i = 0; i < 6; i++) push_a(18'($urandom));
      chk("pre_rst_level", 32'(level_a), 5);
      chk("pre_rst_busy", 32'(busy_a), 1);
      rst = 0;
      sb_a.delete();
      #1;
      chk("mid_rst_level", 32'(level_a), 0);
      chk("mid_rst_din", 32'(ifa.din), 0);
      chk("mid_rst_din_valid", 32'(ifa.din_valid), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_s_ready", 32'(ifa.s_ready), 0);
      chk("mid_rst_err", 32'(err_a), 0);
      @(posedge clk); #2;
      rst = 1;
      c = dv_a;
      cycles(30);
      chk("no_stale_issue", 32'(dv_a - c), 0);

      // 6: push and pop in the same cycle at level DEPTH-1
      done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         ifa.s_valid = 0;
         if (level_a == 4'd7 && ifa.dout_valid && busy_a) begin
            ifa.s_data = 18'($urandom); ifa.s_valid = 1; done = 1;
         end else if (level_a < 4'd7) begin
            ifa.s_data = 18'($urandom); ifa.s_valid = 1;
         end
         @(posedge clk); #2;
      end
      ifa.s_valid = 0;
      chk("coincide_reached", 32'(done), 1);
      chk("coincide_level", 32'(level_a), 7);
      wait_idle_a();
      chk("sb_a_empty_t6", 32'(sb_a.size()), 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         ifa.s_valid = ($urandom_range(0, 3) == 0);
         ifa.s_data  = 18'($urandom);
         @(posedge clk); #2;
      end
      ifa.s_valid = 0;
      wait_idle_a();
      chk("sb_a_empty_final", 32'(sb_a.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
